// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: interface width defaults,
// FSM state encoding and the read-latency counter width.
package mem_responder_pkg;

    localparam int DEF_MEM_ADDR_BITS = 28;
    localparam int DEF_MEM_DATA_BITS = 128;
    localparam int DEF_MEM_TAG_BITS  = 5;

    // Wide enough for the largest legal RD_LATENCY (15).
    localparam int CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_line_ram.sv
// Single-port line store: registered read, byte-masked synchronous write.
// Each byte lane is its own array so the write enable maps onto RAM byte enables.
module mem_line_ram #(
    parameter int DATA_BITS  = 128,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                    clk,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_BITS/8-1:0]  wmask,
    input  logic [DATA_BITS-1:0]    wdata,
    output logic [DATA_BITS-1:0]    rdata
);

    localparam int LANES = DATA_BITS / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk) begin
                if (we && wmask[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                lane_rdata_reg <= lane_mem[addr];
            end

            assign rdata[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write request at a time, stores lines
// in mem_line_ram and returns read data a fixed RD_LATENCY cycles after accept.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int MEM_TAG_BITS  = DEF_MEM_TAG_BITS,
    parameter int DEPTH_LOG2    = 12,
    parameter int RD_LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    state_t                    state_reg, state_next;
    logic [CNT_BITS-1:0]       cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0]     addr_reg;
    logic [MEM_TAG_BITS-1:0]   tag_reg;
    logic [MEM_TAG_BITS-1:0]   mem_resp_tag_reg;
    logic [MEM_DATA_BITS-1:0]  mem_resp_data_reg;

    logic                      req_fire;
    logic                      ram_we;
    logic                      resp_load;
    logic [DEPTH_LOG2-1:0]     ram_addr;
    logic [MEM_DATA_BITS-1:0]  ram_rdata;

    // Upper address bits alias onto the same stored line.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];

    assign mem_req_ready      = (state_reg == ST_IDLE)  && !reset;
    assign mem_req_data_ready = (state_reg == ST_WDATA) && !reset;
    assign mem_resp_valid     = (state_reg == ST_RESP)  && !reset;
    assign mem_resp_tag       = mem_resp_tag_reg;
    assign mem_resp_data      = mem_resp_data_reg;
    assign req_fire           = mem_req_valid && mem_req_ready;

    // In IDLE the RAM is addressed straight from the request so a read fired
    // this cycle already has its line in the RAM output register next cycle.
    assign ram_addr = (state_reg == ST_IDLE) ? mem_req_addr[DEPTH_LOG2-1:0] : addr_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ram_we     = 1'b0;
        resp_load  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    if (mem_req_rw) begin
                        state_next = ST_WDATA;
                    end else begin
                        state_next = ST_RWAIT;
                        cnt_next   = CNT_BITS'(RD_LATENCY - 2);
                    end
                end
            end
            ST_WDATA: begin
                if (mem_req_data_valid && mem_req_data_ready) begin
                    ram_we     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RWAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                    resp_load  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_BITS'(1);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            mem_resp_tag_reg  <= '0;
            mem_resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (req_fire) begin
                addr_reg <= mem_req_addr[DEPTH_LOG2-1:0];
                tag_reg  <= mem_req_tag;
            end
            if (resp_load) begin
                mem_resp_tag_reg  <= tag_reg;
                mem_resp_data_reg <= ram_rdata;
            end
        end
    end

    mem_line_ram #(
        .DATA_BITS  (MEM_DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wmask (mem_req_data_mask),
        .wdata (mem_req_data_bits),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes expected read responses into
// a queue, an independent monitor pops and compares each presented response.
module tb_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [127:0] mem_resp_data;

    mem_responder dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]   tag;
        logic [127:0] data;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [127:0] D1    = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] D1_AA = 128'h0123456789ABCDEF_0123456789ABCDAA;
    localparam logic [127:0] D2    = 128'h0011223344556677_8899AABBCCDDEEFF;
    localparam logic [127:0] D2_M  = 128'hA5A5A5A544556677_8899AABBA5A5A5A5;
    localparam logic [127:0] DA5   = {16{8'hA5}};
    localparam logic [127:0] D3    = 128'hDEADBEEF00000000_CAFEF00D12345678;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation,
    // arrive in the predicted cycle and last exactly one cycle.
    logic prev_resp_valid = 1'b0;
    always @(negedge clk) begin
        if (mem_resp_valid) begin
            if (prev_resp_valid) begin
                checks++;
                failures++;
                $display("FAIL resp_width: valid high in consecutive cycles at cyc %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: tag %0d data %h at cyc %0d", mem_resp_tag, mem_resp_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("resp_tag(t%0d)", e.tag), 128'(mem_resp_tag), 128'(e.tag));
                chk($sformatf("resp_data(t%0d)", e.tag), mem_resp_data, e.data);
                chk($sformatf("resp_cycle(t%0d)", e.tag), 128'(cyc), 128'(e.cyc));
            end
        end
        prev_resp_valid = mem_resp_valid;
    end

    // Waits for the request already being driven to be accepted; returns the accept cycle.
    task automatic wait_fire(input string name, output int fcyc);
        fcyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                fcyc = cyc;
                break;
            end
        end
        checks++;
        if (fcyc < 0) begin
            failures++;
            $display("FAIL %s_fire: request not accepted within 50 cycles", name);
        end
    endtask

    task automatic do_write(input logic [27:0] a, input logic [127:0] d,
                            input logic [15:0] m, input bit early);
        int f;
        int n;
        @(posedge clk); #1;
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = a;
        mem_req_tag        = 5'd0;
        mem_req_data_bits  = d;
        mem_req_data_mask  = m;
        mem_req_data_valid = early;
        wait_fire($sformatf("wr_%h", a), f);
        chk("wr_dready_low_at_fire", 128'(mem_req_data_ready), 128'(0));
        @(posedge clk); #1;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req_data_ready) begin
                n = i;
                break;
            end
        end
        chk("wr_dready_one_cycle_after_fire", 128'(n), 128'(1));
        @(posedge clk); #1;
        mem_req_data_valid = 1'b0;
        @(negedge clk);
        chk("wr_dready_drops", 128'(mem_req_data_ready), 128'(0));
        chk("wr_ready_returns", 128'(mem_req_ready), 128'(1));
    endtask

    task automatic do_read(input logic [27:0] a, input logic [4:0] t,
                           input logic [127:0] exp, input bit push);
        int f;
        @(posedge clk); #1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = a;
        mem_req_tag   = t;
        wait_fire($sformatf("rd_t%0d", t), f);
        if (push && f >= 0) exp_q.push_back('{t, exp, f + 4});
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic drain;
        int i;
        for (i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int f1;
        int f2;
        int seen;
        reset              = 1'b1;
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        // Reset state: nothing accepted while reset is high, outputs cleared after.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 128'(mem_req_ready), 128'(0));
        chk("rst_data_ready", 128'(mem_req_data_ready), 128'(0));
        chk("rst_resp_valid", 128'(mem_resp_valid), 128'(0));
        @(posedge clk); #1;
        reset              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 128'(mem_req_ready), 128'(1));
        chk("post_rst_resp_tag", 128'(mem_resp_tag), 128'(0));
        chk("post_rst_resp_data", mem_resp_data, 128'(0));

        // Full write then read: tag 3 returns the line four cycles after accept.
        do_write(28'h10, D1, 16'hFFFF, 1'b0);
        do_read(28'h10, 5'd3, D1, 1'b1);
        drain();

        // Single-byte masked write.
        do_write(28'h10, 128'hAA, 16'h0001, 1'b0);
        do_read(28'h10, 5'd4, D1_AA, 1'b1);
        drain();

        // Write data offered in the same cycle as the request.
        do_write(28'h20, D2, 16'hFFFF, 1'b1);
        do_write(28'h20, DA5, 16'hF00F, 1'b1);
        do_read(28'h20, 5'd10, D2_M, 1'b1);
        drain();

        // All-zero mask leaves the line untouched.
        do_write(28'h20, 128'h0, 16'h0000, 1'b0);
        do_read(28'h20, 5'd11, D2_M, 1'b1);
        drain();

        // Back-to-back reads with valid held high.
        @(posedge clk); #1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'h10;
        mem_req_tag   = 5'd1;
        wait_fire("b2b_first", f1);
        if (f1 >= 0) exp_q.push_back('{5'd1, D1_AA, f1 + 4});
        @(posedge clk); #1;
        mem_req_addr = 28'h20;
        mem_req_tag  = 5'd2;
        wait_fire("b2b_second", f2);
        if (f2 >= 0) exp_q.push_back('{5'd2, D2_M, f2 + 4});
        chk("b2b_second_accept_cycle", 128'(f2 - f1), 128'(5));
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        drain();

        // Address aliasing onto the low DEPTH_LOG2 bits.
        do_read(28'h1010, 5'd5, D1_AA, 1'b1);
        do_write(28'h2030, D3, 16'hFFFF, 1'b0);
        do_read(28'h30, 5'd6, D3, 1'b1);
        drain();

        // Reset while a read is waiting: the response must never appear.
        do_read(28'h10, 5'd7, D1_AA, 1'b0);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_resp_valid) seen++;
        end
        chk("rst_mid_read_no_resp", 128'(seen), 128'(0));
        chk("rst_mid_read_ready", 128'(mem_req_ready), 128'(1));
        do_read(28'h10, 5'd8, D1_AA, 1'b1);
        drain();

        // Reset while waiting for write data: the write is dropped.
        @(posedge clk); #1;
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 28'h10;
        mem_req_data_bits  = 128'h0;
        mem_req_data_mask  = 16'hFFFF;
        mem_req_data_valid = 1'b0;
        wait_fire("rst_mid_write", f1);
        @(posedge clk); #1;
        mem_req_valid      = 1'b0;
        reset              = 1'b1;
        mem_req_data_valid = 1'b1;
        @(posedge clk); #1;
        reset              = 1'b0;
        mem_req_data_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_ready", 128'(mem_req_ready), 128'(1));
        do_read(28'h10, 5'd9, D1_AA, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
